// File: rtl/hazard_stall_ctrl_pkg.sv
// hazard_stall_ctrl_pkg: FSM encoding, default latency and pipeline control words
package hazard_stall_ctrl_pkg;
  typedef enum logic {RUN = 1'b0, MD_BUSY = 1'b1} state_e;
  localparam int MD_LATENCY_DEF = 4;
  localparam int MD_CNT_W = 4;
  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_flush;
  } ctrl_t;
  localparam ctrl_t CTRL_PASS  = 4'b1100;
  localparam ctrl_t CTRL_STALL = 4'b0001;
  localparam ctrl_t CTRL_FLUSH = 4'b1111;
endpackage

// File: rtl/hazard_stall_ctrl_lud.sv
// loadUseDetect: flags a load in ID/EX whose destination feeds the instruction in IF/ID
module loadUseDetect (
  input  logic       idExMemRead,
  input  logic [4:0] idExRt,
  input  logic [4:0] ifIdRs,
  input  logic [4:0] ifIdRt,
  output logic       hazard
);
  assign hazard = idExMemRead && (idExRt != 5'd0) && (idExRt == ifIdRs || idExRt == ifIdRt);
endmodule

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: load-use/branch/multiply-divide stall and flush control with stall statistic
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int MD_LATENCY = MD_LATENCY_DEF,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             idExMemRead,
  input  logic [4:0]       idExRt,
  input  logic [4:0]       ifIdRs,
  input  logic [4:0]       ifIdRt,
  input  logic             mdStart,
  input  logic             branchTaken,
  output logic             pcWrite,
  output logic             ifIdWrite,
  output logic             ifIdFlush,
  output logic             idExFlush,
  output logic             mdBusy,
  output logic             mdDone,
  output logic [CNT_W-1:0] stallCycles
);
  state_e              state_q, state_d;
  logic [MD_CNT_W-1:0] cnt_q, cnt_d;
  logic                hold_q, hold_d;
  logic [CNT_W-1:0]    stall_q, stall_d;
  logic                load_use;
  ctrl_t               ctrl;
  loadUseDetect u_lud (
    .idExMemRead(idExMemRead),
    .idExRt     (idExRt),
    .ifIdRs     (ifIdRs),
    .ifIdRt     (ifIdRt),
    .hazard     (load_use)
  );
  // hold_q blocks a held-high mdStart from relaunching an op until it drops in RUN
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    ctrl    = CTRL_PASS;
    mdBusy  = 1'b0;
    mdDone  = 1'b0;
    if (state_q == MD_BUSY) begin
      ctrl    = CTRL_STALL;
      mdBusy  = 1'b1;
      mdDone  = (cnt_q == '0) && !reset;
      state_d = (cnt_q == '0) ? RUN : MD_BUSY;
      cnt_d   = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
    end else begin
      hold_d = hold_q && mdStart;
      if (branchTaken) ctrl = CTRL_FLUSH;
      else if (load_use) ctrl = CTRL_STALL;
      else if (mdStart && !hold_q) begin
        ctrl    = CTRL_STALL;
        state_d = MD_BUSY;
        cnt_d   = MD_CNT_W'(MD_LATENCY - 1);
        hold_d  = 1'b1;
      end
    end
    stall_d = (!ctrl.pc_write && stall_q != '1) ? stall_q + 1'b1 : stall_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
      hold_q  <= 1'b0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      stall_q <= stall_d;
    end
  end
  assign pcWrite     = ctrl.pc_write;
  assign ifIdWrite   = ctrl.if_id_write;
  assign ifIdFlush   = ctrl.if_id_flush;
  assign idExFlush   = ctrl.id_ex_flush;
  assign stallCycles = stall_q;
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed checks of stall/flush control, MD sequencing and saturation
module tb_hazard_stall_ctrl;
  logic       clk = 1'b0;
  logic       reset, idExMemRead, mdStart, branchTaken;
  logic [4:0] idExRt, ifIdRs, ifIdRt;
  logic       pcWrite, ifIdWrite, ifIdFlush, idExFlush, mdBusy, mdDone;
  logic [3:0] stallCycles;
  int errs = 0, checks = 0;
  int pc_low, busy, done_n, done_at;
  always #5 clk = ~clk;
  hazard_stall_ctrl #(.MD_LATENCY(4), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .idExMemRead(idExMemRead), .idExRt(idExRt),
    .ifIdRs(ifIdRs), .ifIdRt(ifIdRt), .mdStart(mdStart), .branchTaken(branchTaken),
    .pcWrite(pcWrite), .ifIdWrite(ifIdWrite), .ifIdFlush(ifIdFlush), .idExFlush(idExFlush),
    .mdBusy(mdBusy), .mdDone(mdDone), .stallCycles(stallCycles)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic drive(input logic mr, input logic [4:0] er, input logic [4:0] rs,
                       input logic [4:0] rt, input logic md, input logic br);
    idExMemRead = mr;
    idExRt = er;
    ifIdRs = rs;
    ifIdRt = rt;
    mdStart = md;
    branchTaken = br;
    #1;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    tick();
    reset = 1'b0;
    #1;
  endtask
  task automatic md_run(input int n, input logic hold_md);
    pc_low = 0; busy = 0; done_n = 0; done_at = -1;
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 0, 0, hold_md || i == 0, 0);
      if (!pcWrite) pc_low++;
      if (mdBusy) busy++;
      if (mdDone) begin done_n++; done_at = i; end
      tick();
    end
  endtask
  initial begin
    do_reset();
    check("rst_pcWrite", 32'(pcWrite), 1);
    check("rst_ifIdWrite", 32'(ifIdWrite), 1);
    check("rst_ifIdFlush", 32'(ifIdFlush), 0);
    check("rst_idExFlush", 32'(idExFlush), 0);
    check("rst_mdBusy", 32'(mdBusy), 0);
    check("rst_mdDone", 32'(mdDone), 0);
    check("rst_stall", 32'(stallCycles), 0);
    drive(1, 5, 5, 0, 0, 0);
    check("lu_rs_pcWrite", 32'(pcWrite), 0);
    check("lu_rs_ifIdWrite", 32'(ifIdWrite), 0);
    check("lu_rs_idExFlush", 32'(idExFlush), 1);
    check("lu_rs_ifIdFlush", 32'(ifIdFlush), 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    check("lu_rel_pcWrite", 32'(pcWrite), 1);
    check("lu_rel_ifIdWrite", 32'(ifIdWrite), 1);
    check("lu_rel_idExFlush", 32'(idExFlush), 0);
    check("lu_rel_stall", 32'(stallCycles), 1);
    drive(1, 7, 3, 7, 0, 0);
    check("lu_rt_pcWrite", 32'(pcWrite), 0);
    tick();
    drive(1, 0, 0, 0, 0, 0);
    check("lu_r0_pcWrite", 32'(pcWrite), 1);
    check("lu_r0_idExFlush", 32'(idExFlush), 0);
    drive(0, 9, 9, 9, 0, 0);
    check("noload_pcWrite", 32'(pcWrite), 1);
    drive(1, 9, 8, 10, 0, 0);
    check("nomatch_pcWrite", 32'(pcWrite), 1);
    check("lu_rt_stall", 32'(stallCycles), 2);
    do_reset();
    md_run(8, 0);
    check("md_pc_low", pc_low, 5);
    check("md_busy", busy, 4);
    check("md_done_n", done_n, 1);
    check("md_done_at", done_at, 4);
    check("md_stall", 32'(stallCycles), 5);
    check("md_after_pcWrite", 32'(pcWrite), 1);
    do_reset();
    md_run(10, 1);
    check("hold_pc_low", pc_low, 5);
    check("hold_done_n", done_n, 1);
    drive(0, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 1, 0);
    check("rearm_pcWrite", 32'(pcWrite), 0);
    tick();
    check("rearm_mdBusy", 32'(mdBusy), 1);
    md_run(6, 0);
    do_reset();
    drive(1, 5, 5, 0, 1, 0);
    check("lu_md_pcWrite", 32'(pcWrite), 0);
    tick();
    check("lu_md_noBusy", 32'(mdBusy), 0);
    drive(0, 0, 0, 0, 1, 0);
    check("lu_md_retry_pcWrite", 32'(pcWrite), 0);
    tick();
    check("lu_md_retry_busy", 32'(mdBusy), 1);
    do_reset();
    drive(1, 5, 5, 0, 0, 1);
    check("br_ifIdFlush", 32'(ifIdFlush), 1);
    check("br_idExFlush", 32'(idExFlush), 1);
    check("br_pcWrite", 32'(pcWrite), 1);
    check("br_ifIdWrite", 32'(ifIdWrite), 1);
    drive(0, 0, 0, 0, 1, 1);
    check("br_md_pcWrite", 32'(pcWrite), 1);
    tick();
    check("br_md_noBusy", 32'(mdBusy), 0);
    check("br_stall", 32'(stallCycles), 0);
    drive(0, 0, 0, 0, 1, 0);
    tick();
    drive(1, 5, 5, 0, 0, 1);
    check("busy_br_ifIdFlush", 32'(ifIdFlush), 0);
    check("busy_br_pcWrite", 32'(pcWrite), 0);
    check("busy_br_mdBusy", 32'(mdBusy), 1);
    do_reset();
    drive(0, 0, 0, 0, 1, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    tick();
    check("abort_in_busy", 32'(mdBusy), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("abort_mdBusy", 32'(mdBusy), 0);
    check("abort_mdDone", 32'(mdDone), 0);
    check("abort_pcWrite", 32'(pcWrite), 1);
    check("abort_stall", 32'(stallCycles), 0);
    md_run(5, 0);
    do_reset();
    drive(1, 5, 5, 0, 0, 0);
    repeat (14) tick();
    check("sat_pre", 32'(stallCycles), 14);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("sat_hold", 32'(stallCycles), 15);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
